// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared types and constants for the pipeline front-end.
// Rev     : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int unsigned PIPE_XLEN = 32;
    localparam logic [PIPE_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] ir;
        logic                 valid;
    } stage_reg_t;

    function automatic stage_reg_t nop_stage();
        stage_reg_t s;
        s.pc    = '0;
        s.ir    = NOP_INSTR;
        s.valid = 1'b0;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : fetch_skid_buf
// Brief   : One-entry holding slot for a fetch response that lands during a stall.
// Rev     : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import pipe_pkg::*;
#(
    parameter int XLEN = PIPE_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_ir,
    output logic            o_full,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_ir
);

    logic            r_full;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ir;

    // Clear dominates so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_pc   <= '0;
            r_ir   <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_pc   <= i_pc;
            r_ir   <= i_ir;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_pc   = r_pc;
    assign o_ir   = r_ir;

endmodule
`default_nettype wire

// File: rtl/pipe_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_fetch_ctrl
// Brief   : Fetch PC, imem handshake and F->D->E registers with stall/flush/trap.
//           Define PIPE_PERF_CNT_EN to enable the stall/flush perf counters.
// Rev     : 1.0 - initial release
// ============================================================================
module pipe_fetch_ctrl
    import pipe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_valid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_D_o,
    output logic [XLEN-1:0] ir_D_o,
    output logic            valid_D_o,
    output logic [XLEN-1:0] pc_E_o,
    output logic [XLEN-1:0] ir_E_o,
    output logic            valid_E_o,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
);

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nx;
    logic [XLEN-1:0] r_pc_f;
    logic [XLEN-1:0] w_pc_f_nx;
    logic [XLEN-1:0] r_drain_addr;
    logic            r_outst;
    stage_reg_t      r_d;
    stage_reg_t      r_e;
    stage_reg_t      w_d_nx;
    stage_reg_t      w_e_nx;

    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            w_resp;
    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_push;
    logic            w_pop;
    logic            w_clear;
    logic            w_skid_full;
    logic [XLEN-1:0] w_skid_pc;
    logic [XLEN-1:0] w_skid_ir;

    fetch_skid_buf #(
        .XLEN (XLEN)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_pc    (r_pc_f),
        .i_ir    (imem_rdata_i),
        .o_full  (w_skid_full),
        .o_pc    (w_skid_pc),
        .o_ir    (w_skid_ir)
    );

    // DRAIN keeps the old request up; a full skid buffer is drained before new fetches.
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_pc_f;
        if (!rst) begin
            if (r_state == DRAIN) begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
            end else begin
                w_req = !w_skid_full && !(stall_i && !r_outst);
            end
        end
    end

    assign w_resp     = imem_valid_i && w_req;
    assign w_redirect = trap_i || flush_i;
    assign w_target   = trap_i ? trap_pc_i : br_target_i;

    always_comb begin
        w_state_nx = r_state;
        w_pc_f_nx  = r_pc_f;
        w_d_nx     = r_d;
        w_e_nx     = r_e;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_clear    = 1'b0;
        if (w_redirect) begin
            w_pc_f_nx  = w_target;
            w_d_nx     = nop_stage();
            w_e_nx     = nop_stage();
            w_clear    = 1'b1;
            w_state_nx = (w_req && !imem_valid_i) ? DRAIN : FETCH;
        end else if (r_state == DRAIN) begin
            if (imem_valid_i) begin
                w_state_nx = FETCH;
            end
            if (stall_i) begin
                w_e_nx = nop_stage();
            end else begin
                w_e_nx = r_d;
                w_d_nx = nop_stage();
            end
        end else if (stall_i) begin
            w_e_nx = nop_stage();
            if (w_resp) begin
                w_push    = 1'b1;
                w_pc_f_nx = r_pc_f + c_PC_STEP;
            end
        end else begin
            w_e_nx = r_d;
            if (w_skid_full) begin
                w_d_nx = '{pc: w_skid_pc, ir: w_skid_ir, valid: 1'b1};
                w_pop  = 1'b1;
            end else if (w_resp) begin
                w_d_nx    = '{pc: r_pc_f, ir: imem_rdata_i, valid: 1'b1};
                w_pc_f_nx = r_pc_f + c_PC_STEP;
            end else begin
                w_d_nx = nop_stage();
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc_f       <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_outst      <= 1'b0;
            r_d          <= nop_stage();
            r_e          <= nop_stage();
        end else begin
            r_state      <= w_state_nx;
            r_pc_f       <= w_pc_f_nx;
            r_drain_addr <= w_addr;
            r_outst      <= w_req && !imem_valid_i;
            r_d          <= w_d_nx;
            r_e          <= w_e_nx;
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = w_addr;
    assign pc_D_o      = r_d.pc;
    assign ir_D_o      = r_d.ir;
    assign valid_D_o   = r_d.valid;
    assign pc_E_o      = r_e.pc;
    assign ir_E_o      = r_e.ir;
    assign valid_E_o   = r_e.valid;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_i) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_redirect) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_fetch_ctrl
// Brief   : Directed bench with a rule-level pipeline model and an imem responder.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_pipe_fetch_ctrl;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, trap_i;
    logic [31:0] br_target_i, trap_pc_i;
    logic        imem_req_o, imem_valid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] pc_D_o, ir_D_o, pc_E_o, ir_E_o;
    logic        valid_D_o, valid_E_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    pipe_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .br_target_i  (br_target_i),
        .trap_i       (trap_i),
        .trap_pc_i    (trap_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_valid_i (imem_valid_i),
        .imem_rdata_i (imem_rdata_i),
        .pc_D_o       (pc_D_o),
        .ir_D_o       (ir_D_o),
        .valid_D_o    (valid_D_o),
        .pc_E_o       (pc_E_o),
        .ir_E_o       (ir_E_o),
        .valid_E_o    (valid_E_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
    );

    int checks   = 0;
    int failures = 0;

    // Model: fetch PC, D/E slots, held response, pending-redirect flag.
    logic [31:0] m_pcF, m_dpc, m_dir, m_epc, m_eir, m_kpc, m_kir, m_daddr;
    logic        m_dv, m_ev, m_kv, m_drain, m_outst;
    logic [31:0] m_scnt, m_fcnt;

    // Memory responder: word at addr is addr>>2, answered after lat cycles.
    int          lat = 0;
    bit          busy = 0;
    int          cnt = 0;
    logic [31:0] raddr = '0;
    int          req_c = 0;
    logic        last_req;
    logic [31:0] last_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pcF = 32'h0; m_daddr = 32'h0;
        m_dpc = 32'h0; m_dir = c_NOP; m_dv = 1'b0;
        m_epc = 32'h0; m_eir = c_NOP; m_ev = 1'b0;
        m_kv = 1'b0; m_kpc = 32'h0; m_kir = 32'h0;
        m_drain = 1'b0; m_outst = 1'b0;
        m_scnt = 32'h0; m_fcnt = 32'h0;
    endtask

    task automatic step(input bit r, input bit st, input bit fl, input logic [31:0] br,
                        input bit tr, input logic [31:0] tp);
        logic        er;
        logic [31:0] ea;
        bit          v;
        rst = r; stall_i = st; flush_i = fl; br_target_i = br; trap_i = tr; trap_pc_i = tp;
        imem_valid_i = 1'b0;
        #1;
        er = !r && (m_drain || (!m_kv && !(st && !m_outst)));
        ea = m_drain ? m_daddr : m_pcF;
        last_req  = imem_req_o;
        last_addr = imem_addr_o;
        chk("imem_req", {31'b0, imem_req_o}, {31'b0, er});
        if (er) chk("imem_addr", imem_addr_o, ea);
        chk("valid_D", {31'b0, valid_D_o}, {31'b0, m_dv});
        chk("ir_D", ir_D_o, m_dir);
        if (m_dv) chk("pc_D", pc_D_o, m_dpc);
        chk("valid_E", {31'b0, valid_E_o}, {31'b0, m_ev});
        chk("ir_E", ir_E_o, m_eir);
        if (m_ev) chk("pc_E", pc_E_o, m_epc);
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", stall_cnt_o, m_scnt);
        chk("flush_cnt", flush_cnt_o, m_fcnt);
`else
        chk("stall_cnt", stall_cnt_o, 32'h0);
        chk("flush_cnt", flush_cnt_o, 32'h0);
`endif
        if (!busy && imem_req_o) begin
            busy  = 1;
            cnt   = lat;
            raddr = imem_addr_o;
            if (raddr == 32'hC) req_c++;
        end
        v = busy && (cnt == 0);
        imem_valid_i = v;
        imem_rdata_i = raddr >> 2;

        if (r) begin
            model_reset();
        end else begin
            if (st) m_scnt = m_scnt + 1;
            if (tr || fl) begin
                // Redirect: both slots killed, held response lost, old request drained.
                m_fcnt  = m_fcnt + 1;
                m_daddr = ea;
                m_drain = er && !v;
                m_pcF   = tr ? tp : br;
                m_dpc = 0; m_dir = c_NOP; m_dv = 0;
                m_epc = 0; m_eir = c_NOP; m_ev = 0;
                m_kv  = 0;
            end else if (m_drain) begin
                if (v) m_drain = 0;
                if (st) begin
                    m_epc = 0; m_eir = c_NOP; m_ev = 0;
                end else begin
                    m_epc = m_dpc; m_eir = m_dir; m_ev = m_dv;
                    m_dpc = 0; m_dir = c_NOP; m_dv = 0;
                end
            end else if (st) begin
                m_epc = 0; m_eir = c_NOP; m_ev = 0;
                if (v && er) begin
                    m_kv = 1; m_kpc = m_pcF; m_kir = raddr >> 2;
                    m_pcF = m_pcF + 4;
                end
            end else begin
                m_epc = m_dpc; m_eir = m_dir; m_ev = m_dv;
                if (m_kv) begin
                    m_dpc = m_kpc; m_dir = m_kir; m_dv = 1; m_kv = 0;
                end else if (v && er) begin
                    m_dpc = m_pcF; m_dir = raddr >> 2; m_dv = 1;
                    m_pcF = m_pcF + 4;
                end else begin
                    m_dpc = 0; m_dir = c_NOP; m_dv = 0;
                end
            end
            m_outst = er && !v;
        end

        @(posedge clk);
        #1;
        if (busy) begin
            if (v) busy = 0;
            else   cnt--;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; stall_i = 0; flush_i = 0; trap_i = 0;
        br_target_i = 0; trap_pc_i = 0; imem_valid_i = 0; imem_rdata_i = 0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_req", {31'b0, last_req}, 32'h0);
        chk("rst_irD", ir_D_o, c_NOP);
        chk("rst_vD", {31'b0, valid_D_o}, 32'h0);
        chk("rst_pcE", pc_E_o, 32'h0);

        // Zero-wait streaming
        lat = 0;
        step(0, 0, 0, 0, 0, 0); chk("t1_addr0", last_addr, 32'h0); chk("t1_irD0", ir_D_o, 32'h0);
        chk("t1_vD", {31'b0, valid_D_o}, 32'h1);
        step(0, 0, 0, 0, 0, 0); chk("t1_addr4", last_addr, 32'h4); chk("t1_irD1", ir_D_o, 32'h1);
        step(0, 0, 0, 0, 0, 0); chk("t1_addr8", last_addr, 32'h8); chk("t1_irD2", ir_D_o, 32'h2);

        // Two-cycle stall with pc_D = 0x8
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 0, 0, 0);
            chk("t2_req", {31'b0, last_req}, 32'h0);
            chk("t2_pcD", pc_D_o, 32'h8);
            chk("t2_irE", ir_E_o, c_NOP);
            chk("t2_vE", {31'b0, valid_E_o}, 32'h0);
        end
        step(0, 0, 0, 0, 0, 0);
        chk("t2_pcE", pc_E_o, 32'h8); chk("t2_irE2", ir_E_o, 32'h2);

        // Branch flush
        step(0, 0, 1, 32'h100, 0, 0);
        chk("t3_irD", ir_D_o, c_NOP); chk("t3_irE", ir_E_o, c_NOP);
        chk("t3_vE", {31'b0, valid_E_o}, 32'h0);
        step(0, 0, 0, 0, 0, 0); chk("t3_addr", last_addr, 32'h100);

        // Redirect while 0x10 is outstanding with a 3-cycle-late response
        step(0, 0, 1, 32'h10, 0, 0);
        lat = 3;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h100, 0, 0); chk("t4_addr_a", last_addr, 32'h10);
        step(0, 0, 0, 0, 0, 0);       chk("t4_addr_b", last_addr, 32'h10);
        step(0, 0, 0, 0, 0, 0);       chk("t4_addr_c", last_addr, 32'h10);
        chk("t4_drop", {31'b0, valid_D_o}, 32'h0);
        lat = 0;
        step(0, 0, 0, 0, 0, 0); chk("t4_addr_d", last_addr, 32'h100);
        chk("t4_irD", ir_D_o, 32'h40);

        // Trap beats flush and stall
        step(0, 1, 1, 32'h100, 1, 32'h200);
        step(0, 0, 0, 0, 0, 0); chk("t6_addr", last_addr, 32'h200);
`ifdef PIPE_PERF_CNT_EN
        chk("t6_fcnt", flush_cnt_o, 32'd4);
        chk("t6_scnt", stall_cnt_o, 32'd3);
`endif

        // Response lands during a stall for 0xC
        step(0, 0, 1, 32'hC, 0, 0);
        req_c = 0;
        lat = 2;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0); chk("t5_req_held", {31'b0, last_req}, 32'h1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0); chk("t5_req_drop", {31'b0, last_req}, 32'h0);
        lat = 0;
        step(0, 0, 0, 0, 0, 0);
        chk("t5_pcD", pc_D_o, 32'hC); chk("t5_irD", ir_D_o, 32'h3);
        step(0, 0, 0, 0, 0, 0); chk("t5_addr", last_addr, 32'h10);
        chk("t5_reqcnt", req_c, 32'd1);

        // PC wrap
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0); chk("wrap_pcD", pc_D_o, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0); chk("wrap_addr", last_addr, 32'h0);

        // Reset in the middle of a drain, late response arrives during reset
        step(0, 0, 1, 32'h40, 0, 0);
        lat = 3;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h80, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rd_vD", {31'b0, valid_D_o}, 32'h0);
        lat = 0;
        step(0, 0, 0, 0, 0, 0); chk("rd_addr", last_addr, 32'h0);
        chk("rd_irD", ir_D_o, 32'h0);

        // Mixed stall / latency pattern
        for (int i = 0; i < 12; i++) begin
            lat = i % 2;
            step(0, (i % 3) == 1, 0, 0, 0, 0);
        end
        run(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
